demux_1to8_collector: RTL and testbench
=======================================

# demux_1to8_collector

Receive-side counterpart to the 8:1 mux path: it takes the serial bit on `mux_out` together with its 3-bit `selection_in` position and rebuilds the 8-bit word that the mux consumed. Bits can arrive in any order, with gaps between them. When all eight positions have been written, the block presents the completed word for one cycle. Duplicate writes and stalled partial frames are reported. It sits beside the mux in the testbench/DUT loop as the reassembly (deserializing) end.

## Interface
- `SEL_W`, default 3: select width. Number of positions N = 2**SEL_W (8 by default).
- `TIMEOUT_CYC`, default 16: idle cycles allowed mid-frame before abort. 0 disables the timeout.
- `clk` input 1: single clock. All state updates on posedge.
- `rst` input 1: asynchronous, active-high reset.
- `mux_out` input 1: serial data bit to place.
- `selection_in` input SEL_W: bit position for `mux_out`.
- `valid_in` input 1: `mux_out` and `selection_in` are sampled on a posedge where this is high.
- `data_out` output N: last completed word. Holds until the next completion.
- `data_valid` output 1: one-cycle pulse when `data_out` updates.
- `fill_mask` output N: registered mask of positions written in the current frame.
- `dup_err` output 1: one-cycle pulse when a position is rewritten within a frame.
- `timeout_err` output 1: one-cycle pulse when a partial frame is aborted.

## Operation
- Internal state: shadow word `shd[N-1:0]`, `fill_mask`, idle counter `idle_cnt` (width clog2(TIMEOUT_CYC+1)).
- Two states, both derived from `fill_mask`:
  - IDLE: `fill_mask`==0.
  - FILL: `fill_mask`!=0.
- On each posedge with `valid_in`=1 at position s = `selection_in`:
  - `shd[s]` <= `mux_out`, always, including on a duplicate.
  - If `fill_mask[s]` was already 1: `dup_err` pulses next cycle and the mask is unchanged (last write wins).
  - Otherwise `fill_mask[s]` <= 1.
  - `idle_cnt` <= 0.
- Completion: a write that makes (`fill_mask` | onehot(s)) all ones has these effects on the next cycle:
  - `data_out` = `shd` including the new bit.
  - `data_valid` = 1.
  - `fill_mask` = 0, returning to IDLE.
  - `shd` itself is not cleared.
- Timeout (applies only in FILL with TIMEOUT_CYC>0):
  - Each posedge with `valid_in`=0 increments `idle_cnt`.
  - When the incremented value equals TIMEOUT_CYC:
    - `timeout_err` pulses.
    - `fill_mask` <= 0 and `idle_cnt` <= 0.
    - `data_out` is unchanged, and `data_valid` stays 0.
- In IDLE, `idle_cnt` is held at 0.

## Timing
- Reset values (asynchronous, take effect immediately on `rst`=1): `data_out`=0, `data_valid`=0, `fill_mask`=0, `dup_err`=0, `timeout_err`=0, `shd`=0, `idle_cnt`=0.
- Latency: `data_valid` is asserted in the cycle immediately after the posedge that samples the final missing position (1 cycle).
- Back-to-back frames: a write on the completion cycle itself (while `data_valid`=1) starts the next frame. There is no dead cycle.
- Simultaneous `valid_in` and timeout threshold: `valid_in` wins, the counter clears, and there is no `timeout_err`.
- A duplicate never causes completion, so `dup_err` and `data_valid` are never high in the same cycle.
- Reset during FILL: the partial frame is discarded and no pulse is emitted.
- `valid_in`=0 samples are ignored apart from counting toward the timeout.
- Pulses last exactly one cycle unless the triggering condition repeats on the next posedge.

## Test plan
- In-order fill: write sel 0..7 on consecutive cycles with bits of 0xA5 (LSB at sel 0).
  - Required: `data_valid`=1 for exactly one cycle, one cycle after sel 7, with `data_out`=0xA5.
  - Required: `fill_mask` steps 0x01, 0x03, … 0x7F, then 0x00.
- Out-of-order with gaps: sel order 7,3,0,5,1,6,2,4 forming 0x3C, with 2 idle cycles between writes and TIMEOUT_CYC=16.
  - Required: `data_out`=0x3C, no error pulses.
- Duplicate: write sel 2=1, then sel 2=0, then the remaining positions with 1s.
  - Required: `dup_err` pulses once after the second write.
  - Required: final `data_out`=0xFB.
- Timeout: write sel 0 and sel 1, then hold `valid_in` low.
  - Required: `timeout_err` pulses exactly 16 cycles after the sel 1 write and `fill_mask` returns to 0.
  - Required: previous `data_out` is retained.
  - Repeat with `valid_in` asserted on the 16th cycle: no `timeout_err`.
- Reset mid-frame: assert `rst` asynchronously after 5 writes.
  - Required: all outputs 0 immediately.
  - Required: a following full 8-write frame of 0x81 completes normally.
- Back-to-back frames: 0x55 then 0xAA with no gap.
  - Required: two `data_valid` pulses 8 cycles apart, with the correct words.

Source files
------------

// File: rtl/demux_1to8_collector.sv
// rtl/demux_1to8_collector.sv - reassembles a word from (bit, position) pairs
// with duplicate detection and a mid-frame idle timeout.
module demux_1to8_collector #(
  parameter int SEL_W       = 3,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mux_out,
  input  logic [SEL_W-1:0]   selection_in,
  input  logic               valid_in,
  output logic [(1<<SEL_W)-1:0] data_out,
  output logic               data_valid,
  output logic [(1<<SEL_W)-1:0] fill_mask,
  output logic               dup_err,
  output logic               timeout_err
);

  localparam int N     = 1 << SEL_W;
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYC > 0);

  logic [N-1:0]     r_shd;
  logic [N-1:0]     r_fill_mask;
  logic [N-1:0]     r_data_out;
  logic             r_data_valid;
  logic             r_dup_err;
  logic             r_timeout_err;
  logic [CNT_W-1:0] r_idle_cnt;

  logic [N-1:0]     w_onehot;
  logic [N-1:0]     w_shd_next;
  logic             w_full;
  logic             w_is_dup;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_to_hit;

  always_comb begin
    w_onehot   = N'(1) << selection_in;
    w_shd_next = r_shd;
    w_shd_next[selection_in] = mux_out;
    w_is_dup   = r_fill_mask[selection_in];
    w_full     = &(r_fill_mask | w_onehot);
    w_cnt_inc  = r_idle_cnt + CNT_W'(1);
    w_to_hit   = TO_EN && (w_cnt_inc == CNT_W'(TIMEOUT_CYC));
  end

  // Pulses default low every cycle; a write always beats the timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shd         <= '0;
      r_fill_mask   <= '0;
      r_data_out    <= '0;
      r_data_valid  <= 1'b0;
      r_dup_err     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_idle_cnt    <= '0;
    end else begin
      r_data_valid  <= 1'b0;
      r_dup_err     <= 1'b0;
      r_timeout_err <= 1'b0;
      if (valid_in) begin
        r_shd      <= w_shd_next;
        r_idle_cnt <= '0;
        if (w_is_dup) begin
          r_dup_err <= 1'b1;
        end else if (w_full) begin
          r_data_out   <= w_shd_next;
          r_data_valid <= 1'b1;
          r_fill_mask  <= '0;
        end else begin
          r_fill_mask <= r_fill_mask | w_onehot;
        end
      end else if (TO_EN && (r_fill_mask != '0)) begin
        if (w_to_hit) begin
          r_timeout_err <= 1'b1;
          r_fill_mask   <= '0;
          r_idle_cnt    <= '0;
        end else begin
          r_idle_cnt <= w_cnt_inc;
        end
      end else begin
        r_idle_cnt <= '0;
      end
    end
  end

  assign data_out    = r_data_out;
  assign data_valid  = r_data_valid;
  assign fill_mask   = r_fill_mask;
  assign dup_err     = r_dup_err;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_demux_1to8_collector.sv
// tb/tb_demux_1to8_collector.sv - scoreboard bench for demux_1to8_collector.
module tb_demux_1to8_collector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mux_out = 1'b0;
  logic [2:0] selection_in = '0;
  logic       valid_in = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic [7:0] fill_mask;
  logic       dup_err;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;
  int dv_cnt = 0;
  int dup_cnt = 0;
  int to_cnt = 0;
  logic [7:0] sb_q[$];

  demux_1to8_collector #(.SEL_W(3), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .mux_out(mux_out), .selection_in(selection_in),
    .valid_in(valid_in), .data_out(data_out), .data_valid(data_valid),
    .fill_mask(fill_mask), .dup_err(dup_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one sample, then returns #1 after the posedge that consumed it.
  task automatic cyc(input logic v, input logic [2:0] s, input logic b);
    valid_in = v;
    selection_in = s;
    mux_out = b;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) begin
        dv_cnt++;
        if (sb_q.size() == 0) chk("unexpected_dv", 32'(data_out), 32'hFFFF_FFFF);
        else chk("word", 32'(data_out), 32'(sb_q.pop_front()));
        if (dup_err) chk("dv_dup_overlap", 32'(dup_err), 32'd0);
      end
      if (dup_err) dup_cnt++;
      if (timeout_err) to_cnt++;
    end
  end

  initial begin
    logic [7:0] w;
    logic [2:0] ord[8];
    int d0, t0;

    #1;
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_dv", 32'(data_valid), 0);
    chk("rst_fill", 32'(fill_mask), 0);
    chk("rst_dup", 32'(dup_err), 0);
    chk("rst_to", 32'(timeout_err), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(0, 0, 0);

    // In-order 0xA5
    w = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) sb_q.push_back(w);
      cyc(1, 3'(i), w[i]);
      chk("inorder_fill", 32'(fill_mask), (i == 7) ? 0 : ((32'd1 << (i + 1)) - 1));
      chk("inorder_dv", 32'(data_valid), (i == 7) ? 1 : 0);
    end
    cyc(0, 0, 0);
    chk("inorder_dv_one", 32'(data_valid), 0);
    chk("inorder_hold", 32'(data_out), 32'hA5);

    // Out-of-order with gaps, 0x3C
    w = 8'h3C;
    ord = '{3'd7, 3'd3, 3'd0, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4};
    d0 = dup_cnt; t0 = to_cnt;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) sb_q.push_back(w);
      cyc(1, ord[i], w[ord[i]]);
      if (i < 7) begin
        cyc(0, 0, 0);
        cyc(0, 0, 0);
      end
    end
    cyc(0, 0, 0);
    chk("ooo_no_dup", 32'(dup_cnt - d0), 0);
    chk("ooo_no_to", 32'(to_cnt - t0), 0);
    chk("ooo_data", 32'(data_out), 32'h3C);

    // Duplicate at sel 2, last write wins -> 0xFB
    cyc(1, 2, 1);
    chk("dup_first", 32'(dup_err), 0);
    cyc(1, 2, 0);
    chk("dup_pulse", 32'(dup_err), 1);
    chk("dup_mask", 32'(fill_mask), 32'h04);
    for (int i = 0; i < 8; i++) begin
      if (i != 2) begin
        if (i == 7) sb_q.push_back(8'hFB);
        cyc(1, 3'(i), 1);
        if (i == 0) chk("dup_pulse_end", 32'(dup_err), 0);
      end
    end
    chk("dup_dv", 32'(data_valid), 1);
    chk("dup_data", 32'(data_out), 32'hFB);
    cyc(0, 0, 0);

    // Timeout after sel0, sel1
    cyc(1, 0, 1);
    cyc(1, 1, 0);
    for (int k = 1; k <= 16; k++) begin
      cyc(0, 0, 0);
      chk($sformatf("to_pulse_%0d", k), 32'(timeout_err), (k == 16) ? 1 : 0);
    end
    chk("to_mask", 32'(fill_mask), 0);
    chk("to_data_kept", 32'(data_out), 32'hFB);
    cyc(0, 0, 0);
    chk("to_pulse_end", 32'(timeout_err), 0);

    // Write on the threshold cycle wins
    cyc(1, 0, 1);
    cyc(1, 1, 0);
    for (int k = 1; k <= 15; k++) cyc(0, 0, 0);
    cyc(1, 2, 1);
    chk("to_suppressed", 32'(timeout_err), 0);
    chk("to_sup_mask", 32'(fill_mask), 32'h07);

    // Reset mid-frame after 5 writes
    cyc(1, 3, 1);
    cyc(1, 4, 1);
    chk("pre_rst_mask", 32'(fill_mask), 32'h1F);
    #2 rst = 1'b1;
    #1;
    chk("arst_data_out", 32'(data_out), 0);
    chk("arst_fill", 32'(fill_mask), 0);
    chk("arst_dv", 32'(data_valid), 0);
    chk("arst_dup", 32'(dup_err), 0);
    chk("arst_to", 32'(timeout_err), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    w = 8'h81;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) sb_q.push_back(w);
      cyc(1, 3'(i), w[i]);
    end
    chk("post_rst_dv", 32'(data_valid), 1);
    cyc(0, 0, 0);

    // Back-to-back 0x55 then 0xAA
    for (int i = 0; i < 16; i++) begin
      w = (i < 8) ? 8'h55 : 8'hAA;
      if (i == 7 || i == 15) sb_q.push_back(w);
      cyc(1, 3'(i % 8), w[i % 8]);
      chk($sformatf("b2b_dv_%0d", i), 32'(data_valid), (i == 7 || i == 15) ? 1 : 0);
    end
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    chk("dv_total", 32'(dv_cnt), 6);
    chk("dup_total", 32'(dup_cnt), 1);
    chk("to_total", 32'(to_cnt), 1);
    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
